// File: rtl/parallelized_result_collector.sv
// Collects one result per lane into per-lane capture slots, then serializes the
// full group onto a single AXI-Stream master in lane order.
module parallelized_result_collector #(
  parameter int PE_NUMBER_I = 1,
  parameter int BATCH_SIZE  = 1,
  parameter int RSLT_WIDTH  = 16,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = ID_ENABLE ? 8 : 1,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = DEST_ENABLE ? 8 : 1,
  parameter int USER_ENABLE = 0,
  parameter int USER_WIDTH  = USER_ENABLE ? 8 : 1,
  parameter int OUTPUT_ID   = 0,
  parameter int OUTPUT_USER = 0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [PE_NUMBER_I*BATCH_SIZE*RSLT_WIDTH-1:0] s_axis_d_tdata,
  input  logic [PE_NUMBER_I*BATCH_SIZE-1:0]            s_axis_d_tvalid,
  input  logic [PE_NUMBER_I*BATCH_SIZE-1:0]            s_axis_d_tlast,
  output logic [PE_NUMBER_I*BATCH_SIZE-1:0]            s_axis_d_tready,
  output logic [RSLT_WIDTH-1:0]                        m_axis_tdata,
  output logic                                         m_axis_tvalid,
  output logic                                         m_axis_tlast,
  input  logic                                         m_axis_tready,
  output logic [ID_WIDTH-1:0]                          m_axis_tid,
  output logic [DEST_WIDTH-1:0]                        m_axis_tdest,
  output logic [USER_WIDTH-1:0]                        m_axis_tuser,
  output logic                                         err_unalligned_last
);

  localparam int LANES = PE_NUMBER_I * BATCH_SIZE;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_DRAIN   = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LANES-1:0]      full_q, full_d;
  logic [LANES-1:0]      last_q, last_d;
  logic                  err_q, err_d;
  logic [RSLT_WIDTH-1:0] data_q [LANES];
  logic [LANES-1:0]      cap;
  logic                  collect, drain, last_beat, m_hs;

  assign collect   = (state_q == ST_COLLECT);
  assign drain     = (state_q == ST_DRAIN);
  assign last_beat = (idx_q == IDX_W'(LANES - 1));
  assign m_hs      = drain & m_axis_tready;

  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign s_axis_d_tready = {LANES{rst_n & collect}} & ~full_q;
  assign cap             = s_axis_d_tvalid & s_axis_d_tready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    full_d  = full_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (collect) begin
      full_d = full_q | cap;
      for (int k = 0; k < LANES; k++) begin
        if (cap[k]) last_d[k] = s_axis_d_tlast[k];
      end
      if (&full_d) begin
        state_d = ST_DRAIN;
        idx_d   = '0;
        err_d   = (|last_d) & ~(&last_d);
      end
    end else if (m_hs) begin
      if (last_beat) begin
        state_d = ST_COLLECT;
        idx_d   = '0;
        full_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      idx_q   <= '0;
      full_q  <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Slot payload needs no reset: it is only observable while its full flag is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (cap[k]) data_q[k] <= s_axis_d_tdata[k*RSLT_WIDTH +: RSLT_WIDTH];
    end
  end

  assign m_axis_tvalid       = drain;
  assign m_axis_tdata        = data_q[idx_q];
  assign m_axis_tlast        = drain & last_beat & (|last_q);
  assign err_unalligned_last = err_q;

  assign m_axis_tid   = (ID_ENABLE != 0)   ? ID_WIDTH'(OUTPUT_ID)     : '0;
  assign m_axis_tuser = (USER_ENABLE != 0) ? USER_WIDTH'(OUTPUT_USER) : '0;

  for (genvar gi = 0; gi < DEST_WIDTH; gi++) begin : g_dest
    if (DEST_ENABLE != 0 && gi < IDX_W) begin : g_idx
      assign m_axis_tdest[gi] = idx_q[gi];
    end else begin : g_zero
      assign m_axis_tdest[gi] = 1'b0;
    end
  end

endmodule

// File: tb/tb_parallelized_result_collector.sv
// Directed bench for the 4-lane collector: group ordering, staggered arrival,
// backpressure, tlast/err handling and reset during drain.
module tb_parallelized_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [3:0]  s_tvalid, s_tlast, s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [0:0]  m_tid, m_tuser;
  logic [7:0]  m_tdest;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parallelized_result_collector #(
    .PE_NUMBER_I(2), .BATCH_SIZE(2), .RSLT_WIDTH(16), .DEST_ENABLE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_d_tdata(s_tdata), .s_axis_d_tvalid(s_tvalid),
    .s_axis_d_tlast(s_tlast), .s_axis_d_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
    .m_axis_tuser(m_tuser), .err_unalligned_last(err)
  );

  typedef struct {
    logic [3:0][15:0] data;
    logic [3:0]       last;
    logic             exp_last;
    logic             exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 of the first DRAIN cycle; leaves at posedge+1 after
  // the cycle following the final beat.
  task automatic check_drain(input logic [3:0][15:0] d, input logic exp_last, input logic exp_err);
    m_tready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk($sformatf("beat%0d_tvalid", b), {31'b0, m_tvalid}, 32'd1);
      chk($sformatf("beat%0d_tdata", b), {16'b0, m_tdata}, {16'b0, d[b]});
      chk($sformatf("beat%0d_tdest", b), {24'b0, m_tdest}, b);
      chk($sformatf("beat%0d_tlast", b), {31'b0, m_tlast}, {31'b0, (b == 3) && exp_last});
      chk($sformatf("beat%0d_err", b), {31'b0, err}, {31'b0, (b == 0) && exp_err});
      chk($sformatf("beat%0d_s_tready", b), {28'b0, s_tready}, 32'h0);
      $display("beat %0d data=0x%04h tdest=%0d tlast=%0b err=%0b", b, m_tdata, m_tdest, m_tlast, err);
      step();
    end
    @(negedge clk);
    chk("post_drain_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("post_drain_s_tready", {28'b0, s_tready}, 32'hF);
    step();
  endtask

  // All four lanes valid in a single cycle, then drain with no backpressure.
  task automatic run_group(input logic [3:0][15:0] d, input logic [3:0] lst,
                           input logic exp_last, input logic exp_err);
    s_tdata  = d;
    s_tlast  = lst;
    s_tvalid = 4'hF;
    m_tready = 1'b1;
    @(negedge clk);
    chk("load_s_tready", {28'b0, s_tready}, 32'hF);
    chk("load_m_tvalid", {31'b0, m_tvalid}, 32'd0);
    step();
    s_tvalid = 4'h0;
    check_drain(d, exp_last, exp_err);
  endtask

  logic [3:0]       stag_valid [6];
  logic [3:0]       stag_ready [6];
  logic [3:0][15:0] d;

  initial begin
    vecs[0] = '{data: {16'h0044, 16'h0033, 16'h0022, 16'h0011}, last: 4'b0000, exp_last: 1'b0, exp_err: 1'b0};
    vecs[1] = '{data: {16'h4004, 16'h3003, 16'h2002, 16'h1001}, last: 4'b1111, exp_last: 1'b1, exp_err: 1'b0};
    // Lane tlast pattern 1,0,1,1 for lanes 0..3.
    vecs[2] = '{data: {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}, last: 4'b1101, exp_last: 1'b1, exp_err: 1'b1};
    vecs[3] = '{data: {16'hFFFF, 16'h0000, 16'h8000, 16'h0001}, last: 4'b1000, exp_last: 1'b1, exp_err: 1'b1};

    rst_n = 1'b0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
    step();
    @(negedge clk);
    chk("reset_s_tready", {28'b0, s_tready}, 32'h0);
    chk("reset_m_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("reset_m_tlast", {31'b0, m_tlast}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("tid_zero", {31'b0, m_tid}, 32'd0);
    chk("tuser_zero", {31'b0, m_tuser}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_s_tready", {28'b0, s_tready}, 32'hF);
    step();

    for (int v = 0; v < 4; v++) begin
      $display("vector %0d last=%04b", v, vecs[v].last);
      run_group(vecs[v].data, vecs[v].last, vecs[v].exp_last, vecs[v].exp_err);
    end

    // Staggered arrival: lane0 c0, lane2 c1, lane1 c3, lane3 c5; lane0 stays
    // valid with changing data to prove a full slot is not overwritten.
    stag_valid = '{4'b0001, 4'b0101, 4'b0001, 4'b0011, 4'b0001, 4'b1001};
    stag_ready = '{4'b1111, 4'b1110, 4'b1010, 4'b1010, 4'b1000, 4'b1000};
    s_tlast = 4'b0000;
    m_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s_tdata  = {16'h3333, 16'h2222, 16'h1111, 16'hA000 + 16'(c)};
      s_tvalid = stag_valid[c];
      @(negedge clk);
      chk($sformatf("stagger_c%0d_s_tready", c), {28'b0, s_tready}, {28'b0, stag_ready[c]});
      chk($sformatf("stagger_c%0d_m_tvalid", c), {31'b0, m_tvalid}, 32'd0);
      $display("stagger cycle %0d valid=%04b tready=%04b", c, s_tvalid, s_tready);
      step();
    end
    s_tvalid = 4'h0;
    check_drain({16'h3333, 16'h2222, 16'h1111, 16'hA000}, 1'b0, 1'b0);

    // Backpressure on beat idx=2 for 10 cycles while inputs keep offering data.
    d = {16'h0D04, 16'h0C03, 16'h0B02, 16'h0A01};
    s_tdata = d; s_tlast = 4'h0; s_tvalid = 4'hF; m_tready = 1'b1;
    step();
    s_tdata = 64'h5555_5555_5555_5555;
    step();
    step();
    m_tready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_tvalid", c), {31'b0, m_tvalid}, 32'd1);
      chk($sformatf("bp%0d_tdata", c), {16'b0, m_tdata}, {16'b0, d[2]});
      chk($sformatf("bp%0d_tdest", c), {24'b0, m_tdest}, 32'd2);
      chk($sformatf("bp%0d_s_tready", c), {28'b0, s_tready}, 32'h0);
      $display("backpressure cycle %0d data=0x%04h", c, m_tdata);
      step();
    end
    m_tready = 1'b1;
    @(negedge clk);
    chk("bp_resume_tdata", {16'b0, m_tdata}, {16'b0, d[2]});
    step();
    @(negedge clk);
    chk("bp_beat3_tdata", {16'b0, m_tdata}, {16'b0, d[3]});
    chk("bp_beat3_tdest", {24'b0, m_tdest}, 32'd3);
    s_tvalid = 4'h0;
    step();
    @(negedge clk);
    chk("bp_done_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("bp_done_s_tready", {28'b0, s_tready}, 32'hF);
    step();

    // Reset during drain after beat 1 has been accepted.
    s_tdata = {16'h0999, 16'h0888, 16'h0777, 16'h0666}; s_tlast = 4'hF; s_tvalid = 4'hF;
    m_tready = 1'b1;
    step();
    s_tvalid = 4'h0;
    @(negedge clk);
    chk("rst_mid_beat0", {16'b0, m_tdata}, 32'h0666);
    step();
    @(negedge clk);
    chk("rst_mid_beat1", {16'b0, m_tdata}, 32'h0777);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_s_tready", {28'b0, s_tready}, 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("rst_mid_s_tready_rel", {28'b0, s_tready}, 32'hF);
    step();
    @(negedge clk);
    chk("rst_mid_idle_tvalid", {31'b0, m_tvalid}, 32'd0);
    step();
    run_group({16'h7004, 16'h7003, 16'h7002, 16'h7001}, 4'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parallelized_result_collector.md
PARALLELIZED_RESULT_COLLECTOR -- requirements
Module: parallelized_result_collector

Interface
REQ-001 Parameter PE_NUMBER_I, default 1: results per batch per run; sets the lane count.
REQ-002 Parameter BATCH_SIZE, default 1: batches per run; LANES = PE_NUMBER_I*BATCH_SIZE.
REQ-003 Parameter RSLT_WIDTH, default 16: width of each result word.
REQ-004 Parameter ID_ENABLE, default 0; ID_WIDTH, default ID_ENABLE?8:1: tid propagation and width.
REQ-005 Parameter DEST_ENABLE, default 0; DEST_WIDTH, default DEST_ENABLE?8:1: tdest propagation and width.
REQ-006 Parameter USER_ENABLE, default 0; USER_WIDTH, default USER_ENABLE?8:1: tuser propagation and width.
REQ-007 Parameter OUTPUT_ID, default 0; OUTPUT_USER, default 0: constant tid and tuser values driven on the output.
REQ-008 clk  input  1  single clock; all logic on the rising edge.
REQ-009 rst_n  input  1  reset, synchronous, active-low.
REQ-010 s_axis_d_tdata  input  LANES*RSLT_WIDTH  per-lane results; lane k occupies bits [k*RSLT_WIDTH +: RSLT_WIDTH].
REQ-011 s_axis_d_tvalid, s_axis_d_tlast  input  LANES each  per-lane valid and last.
REQ-012 s_axis_d_tready  output  LANES  per-lane ready.
REQ-013 m_axis_tdata  output  RSLT_WIDTH  serialized result.
REQ-014 m_axis_tvalid, m_axis_tlast  output  1 each; m_axis_tready  input  1.
REQ-015 m_axis_tid  output  ID_WIDTH; m_axis_tdest  output  DEST_WIDTH; m_axis_tuser  output  USER_WIDTH.
REQ-016 err_unalligned_last  output  1  one-cycle pulse on lane tlast disagreement.

Function
REQ-017 Each lane has one capture slot holding data, tlast and a full flag.
REQ-018 FSM states: COLLECT and DRAIN.
REQ-019 COLLECT behaviour:
  - s_axis_d_tready[k] = !full[k].
  - Lane k captures on its own handshake; lanes are independent, and any number may capture in the same cycle.
REQ-020 Leaving COLLECT: when every slot is full after the current cycle's captures, the FSM enters DRAIN on the next edge, with lane index idx = 0.
REQ-021 DRAIN behaviour:
  - All s_axis_d_tready = 0.
  - m_axis_tvalid = 1, m_axis_tdata = slot[idx].
  - tdata, tlast, tdest and tuser are held stable until the handshake.
REQ-022 DRAIN handshake: on m_axis handshake with idx < LANES-1, idx increments by 1.
REQ-023 DRAIN completion: on handshake with idx = LANES-1:
  - all slots clear, FSM returns to COLLECT, idx = 0;
  - tready is reasserted on the following cycle.
REQ-024 Latency: the first m_axis_tvalid is asserted exactly 1 cycle after the cycle in which the last slot fills. One group of LANES words is emitted per LANES+1 cycles minimum.
REQ-025 m_axis_tlast = 1 only on the idx = LANES-1 beat, and only if the OR of the captured lane tlast bits is 1.
REQ-026 On entry to DRAIN, err_unalligned_last pulses for exactly 1 cycle if the captured tlast bits are neither all 0 nor all 1. Data flow is not altered by this error.
REQ-027 Output sideband:
  - m_axis_tdest = idx (truncated or zero-extended to DEST_WIDTH) when DEST_ENABLE, else 0.
  - m_axis_tid = OUTPUT_ID when ID_ENABLE, else 0.
  - m_axis_tuser = OUTPUT_USER when USER_ENABLE, else 0.
REQ-028 idx width is max(1, clog2(LANES)). With LANES = 1, every group is 1 beat and idx stays 0.
REQ-029 Backpressure: with m_axis_tready held low, the FSM remains in DRAIN indefinitely with outputs stable and no slot lost.

Reset
REQ-030 While rst_n = 0 at a clock edge, the following take effect at that edge:
  - state = COLLECT, idx = 0, all full flags = 0;
  - m_axis_tvalid = 0, m_axis_tlast = 0, err_unalligned_last = 0;
  - s_axis_d_tready = 0 during reset.
REQ-031 After reset: s_axis_d_tready = all ones on the first cycle with rst_n = 1.
REQ-032 Reset asserted mid-COLLECT or mid-DRAIN discards all captured data; no partial group is emitted after release.

Verification (PE_NUMBER_I = 2, BATCH_SIZE = 2, LANES = 4, RSLT_WIDTH = 16, DEST_ENABLE = 1)
REQ-033 Basic order: all 4 lanes valid in one cycle with data 0x0011, 0x0022, 0x0033, 0x0044 and m_axis_tready = 1 -> m_axis emits 0x0011..0x0044 in order, tdest 0..3, on 4 consecutive cycles, first beat 1 cycle after capture; tready returns high afterwards.
REQ-034 Staggered arrival: lanes arrive on cycles 0, 3, 1, 5 (lane 2 on cycle 1, lane 3 on cycle 5) -> each lane's tready drops after its capture; DRAIN starts at cycle 6; output order is still lane 0..3.
REQ-035 Backpressure: m_axis_tready = 0 for 10 cycles during beat idx = 2 -> tdata stays at lane 2 data, tvalid stays 1, and no input is accepted.
REQ-036 tlast handling:
  - all four lane tlast bits = 1 -> tlast on beat 3 only, err = 0;
  - lane tlast pattern 1,0,1,1 -> one err pulse, tlast on beat 3.
REQ-037 Reset mid-DRAIN after beat 1: rst_n = 0 for 1 cycle -> tvalid = 0, no further beats; the next full group emits starting at lane 0.
